// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative RV32M multiply/divide unit, one bit per cycle, fixed
//           33-cycle start->done latency on a shared 65-bit datapath.
// Revision: 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   spec_val_q, spec_val_d;
    logic [2*XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand classification at accept
    logic              w_signed_a, w_signed_b, w_sa, w_sb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic              w_div_zero, w_ovf;
    logic [XLEN-1:0]   w_spec_val;

    always_comb begin
        w_signed_a = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        w_signed_b = funct3[2] ? !funct3[0] : !funct3[1];
        w_sa       = w_signed_a & op_a[XLEN-1];
        w_sb       = w_signed_b & op_b[XLEN-1];
        w_mag_a    = w_sa ? (~op_a + 1'b1) : op_a;
        w_mag_b    = w_sb ? (~op_b + 1'b1) : op_b;
        w_div_zero = (op_b == '0);
        w_ovf      = (funct3 == 3'b100 || funct3 == 3'b110)
                     && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (op_b == {XLEN{1'b1}});
        if (w_div_zero)
            w_spec_val = funct3[1] ? op_a : {XLEN{1'b1}};
        else
            w_spec_val = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One datapath iteration: shift-add multiply or restoring divide step.
    // Multiply keeps {carry, hi, multiplier} and shifts right; divide keeps
    // {remainder, dividend/quotient} and shifts left.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN:0]   w_mul_next;
    logic [2*XLEN:0]   w_div_sh;
    logic [XLEN+1:0]   w_div_diff;
    logic              w_div_ok;
    logic [2*XLEN:0]   w_div_next;
    logic [2*XLEN:0]   w_step;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_fin;

    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                     + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        w_mul_next = {1'b0, w_mul_sum, acc_q[XLEN-1:1]};
        w_div_sh   = {acc_q[2*XLEN-1:0], 1'b0};
        w_div_diff = {1'b0, w_div_sh[2*XLEN:XLEN]} - {2'b00, opb_q};
        w_div_ok   = !w_div_diff[XLEN+1];
        w_div_next = {(w_div_ok ? w_div_diff[XLEN:0] : w_div_sh[2*XLEN:XLEN]),
                      w_div_sh[XLEN-1:1], w_div_ok};
        w_step     = f3_q[2] ? w_div_next : w_mul_next;

        w_prod     = w_step[2*XLEN-1:0];
        w_prod_s   = (sa_q ^ sb_q) ? (~w_prod + 1'b1) : w_prod;
        w_quo      = w_step[XLEN-1:0];
        w_rem      = w_step[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 w_fin = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fin = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fin = (sa_q ^ sb_q) ? (~w_quo + 1'b1) : w_quo;
            default:                w_fin = sa_q ? (~w_rem + 1'b1) : w_rem;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CALC;
                    cnt_d      = '0;
                    f3_d       = funct3;
                    sa_d       = w_sa;
                    sb_d       = w_sb;
                    spec_d     = funct3[2] & (w_div_zero | w_ovf);
                    spec_val_d = w_spec_val;
                    acc_d      = {{(XLEN+1){1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                    opb_d      = funct3[2] ? w_mag_b : w_mag_a;
                end
            end
            S_CALC: begin
                acc_d = w_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d  = S_DONE;
                    result_d = spec_q ? spec_val_q : w_fin;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
`default_nettype wire
